// File: rtl/fetch_unit.sv
// Instruction fetch stage: SPARC-style PC/nPC, imem req/ack reads, IR handed to decode.
// Optional stall counter enabled by defining FETCH_PERF_EN.
module fetch_unit #(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [31:0]       ir_data,
    output logic [ADDR_W-1:0] ir_pc,
    output logic [1:0]        op,
    output logic [5:0]        op3,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   npc_q, npc_d;
    logic [ADDR_W-1:0]   target_al;
    logic                ir_valid_q;
    logic [31:0]         ir_data_q;
    logic [ADDR_W-1:0]   ir_pc_q;
    logic                ack_fire;

    assign ack_fire  = (state_q == FETCH) && imem_ack;
    assign target_al = redirect_target & ~ADDR_W'(3);

    // A redirect always lands in nPC so the delay-slot instruction still issues.
    always_comb begin
        pc_d  = pc_q;
        npc_d = npc_q;
        if (ack_fire) begin
            pc_d  = npc_q;
            npc_d = npc_q + ADDR_W'(4);
        end
        if (redirect_valid) begin
            npc_d = target_al;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            npc_q      <= RESET_PC + ADDR_W'(4);
            ir_valid_q <= 1'b0;
            ir_data_q  <= '0;
            ir_pc_q    <= '0;
        end else begin
            pc_q  <= pc_d;
            npc_q <= npc_d;
            case (state_q)
                IDLE: begin
                    if (fetch_en) state_q <= FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        ir_data_q  <= imem_rdata;
                        ir_pc_q    <= pc_q;
                        ir_valid_q <= 1'b1;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    if (ir_ready) begin
                        ir_valid_q <= 1'b0;
                        state_q    <= fetch_en ? FETCH : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Request is a pure decode of the state flop, so reset drops it immediately.
    assign imem_req  = (state_q == FETCH);
    assign imem_addr = pc_q;
    assign ir_valid  = ir_valid_q;
    assign ir_data   = ir_data_q;
    assign ir_pc     = ir_pc_q;
    assign op        = ir_data_q[31:30];
    assign op3       = ir_data_q[24:19];

`ifdef FETCH_PERF_EN
    logic [15:0] stall_q;

    // Saturating count of cycles spent waiting on imem.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (imem_req && !imem_ack && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default or FETCH_PERF_EN build).
module tb_fetch_unit;

    localparam int unsigned ADDR_W = 32;
`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              fetch_en;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic              ir_valid;
    logic              ir_ready;
    logic [31:0]       ir_data;
    logic [ADDR_W-1:0] ir_pc;
    logic [1:0]        op;
    logic [5:0]        op3;
    logic [15:0]       stall_cnt;

    int total = 0;
    int bad   = 0;

    fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_en        (fetch_en),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .ir_valid        (ir_valid),
        .ir_ready        (ir_ready),
        .ir_data         (ir_data),
        .ir_pc           (ir_pc),
        .op              (op),
        .op3             (op3),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Ack the fetch at cur (optionally with a redirect), then expect the next request at nxt.
    task automatic ack_step(input string tag, input logic [31:0] cur, input logic [31:0] nxt,
                            input logic rv, input logic [31:0] tgt);
        imem_ack        = 1'b1;
        imem_rdata      = cur ^ 32'hA5A5_0000;
        redirect_valid  = rv;
        redirect_target = tgt;
        tick();
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        chk({tag, "_valid"}, ir_valid, 1);
        chk({tag, "_irpc"}, ir_pc, cur);
        chk({tag, "_irdata"}, ir_data, cur ^ 32'hA5A5_0000);
        tick();
        chk({tag, "_req"}, imem_req, 1);
        chk({tag, "_addr"}, imem_addr, nxt);
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_target = '0; ir_ready = 1'b0;
        tick(); tick();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", ir_valid, 0);
        chk("rst_data", ir_data, 0);
        chk("rst_irpc", ir_pc, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_stall", stall_cnt, 0);
        rst = 1'b0;

        // fetch_en low: must stay idle
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_req", imem_req, 0);
        end

        // first fetch, zero-latency ack
        fetch_en = 1'b1; ir_ready = 1'b1;
        tick();
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 0);
        imem_ack = 1'b1; imem_rdata = 32'h8200_4003;
        tick();
        imem_ack = 1'b0;
        chk("t1_valid", ir_valid, 1);
        chk("t1_irpc", ir_pc, 0);
        chk("t1_data", ir_data, 32'h8200_4003);
        chk("t1_op", op, 2'b10);
        chk("t1_op3", op3, 6'b000000);
        chk("t1_req_hold", imem_req, 0);
        tick();
        chk("t1_req2", imem_req, 1);
        chk("t1_addr2", imem_addr, 4);

        // decode back-pressure while holding the PC=4 instruction
        imem_ack = 1'b1; imem_rdata = 32'h9000_0001; ir_ready = 1'b0;
        tick();
        imem_ack = 1'b0;
        chk("t2_irpc", ir_pc, 4);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_req", imem_req, 0);
            chk("t2_valid", ir_valid, 1);
            chk("t2_data", ir_data, 32'h9000_0001);
            chk("t2_irpc_hold", ir_pc, 4);
        end
        ir_ready = 1'b1;
        tick();
        chk("t2_valid_drop", ir_valid, 0);
        chk("t2_req_resume", imem_req, 1);
        chk("t2_addr", imem_addr, 8);

        // redirect with ack: delay slot at 12, then target
        ack_step("t3a", 32'h8, 32'hC, 1'b1, 32'h100);
        ack_step("t3b", 32'hC, 32'h100, 1'b0, 32'h0);
        ack_step("t3c", 32'h100, 32'h104, 1'b0, 32'h0);

        // redirect without ack, misaligned target
        redirect_valid = 1'b1; redirect_target = 32'h203;
        tick();
        redirect_valid = 1'b0;
        chk("t4_req", imem_req, 1);
        chk("t4_addr_held", imem_addr, 32'h104);
        chk("t4_stall", stall_cnt, PERF ? 1 : 0);
        ack_step("t4a", 32'h104, 32'h200, 1'b0, 32'h0);
        ack_step("t4b", 32'h200, 32'h204, 1'b0, 32'h0);

        // nPC wrap past 0xFFFF_FFFC
        ack_step("t6a", 32'h204, 32'h208, 1'b1, 32'hFFFF_FFFC);
        ack_step("t6b", 32'h208, 32'hFFFF_FFFC, 1'b0, 32'h0);
        ack_step("t6c", 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0);
        ack_step("t6d", 32'h0, 32'h4, 1'b0, 32'h0);

        // reset in the middle of a waiting request
        tick(); tick();
        chk("t5_req_wait", imem_req, 1);
        chk("t5_addr_wait", imem_addr, 4);
        chk("t5_stall_pre", stall_cnt, PERF ? 3 : 0);
        rst = 1'b1;
        #1;
        chk("t5_req_async", imem_req, 0);
        chk("t5_addr_async", imem_addr, 0);
        chk("t5_valid_async", ir_valid, 0);
        chk("t5_stall_async", stall_cnt, 0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("t5_late_valid", ir_valid, 0);
        chk("t5_late_data", ir_data, 0);
        rst = 1'b0; fetch_en = 1'b0;
        tick();
        chk("t5_idle_ack_valid", ir_valid, 0);
        chk("t5_idle_ack_req", imem_req, 0);
        imem_ack = 1'b0; fetch_en = 1'b1;
        tick();
        chk("t5_req", imem_req, 1);
        chk("t5_addr", imem_addr, 0);
        chk("t5_stall0", stall_cnt, 0);
        tick(); tick(); tick();
        chk("t5_stall3", stall_cnt, PERF ? 3 : 0);
        chk("t5_req_still", imem_req, 1);
        imem_ack = 1'b1; imem_rdata = 32'h8200_4003;
        tick();
        imem_ack = 1'b0;
        chk("t5_valid", ir_valid, 1);
        chk("t5_irpc", ir_pc, 0);
        chk("t5_stall_final", stall_cnt, PERF ? 3 : 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
